ahb_arbiter: RTL

- Multi-manager AHB bus arbiter: collects bus requests from up to 16 managers and drives one-hot grant.
- Tracks address- and data-phase ownership (HMASTER) and HMASTLOCK.
- Never breaks fixed-length bursts or locked sequences; with the split feature compiled in, masks SPLIT-ed managers until their HSPLIT release.
- Sits between the `ahb_manager` instances and the shared address/control mux; its index outputs drive that mux.

---
 rtl/ahb_arbiter_pkg.sv | 46 ++++
 rtl/ahb_arbiter_if.sv | 40 ++++
 rtl/ahb_arb_rr.sv | 32 +++
 rtl/ahb_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg: AHB bus types, arbiter FSM encodings and burst helper.
// Imported by every file of the arbiter slice.
package ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } t_htrans;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1,
    HR_RETRY = 2'd2,
    HR_SPLIT = 2'd3
  } t_hresp;

  typedef logic [1:0] t_arb_state;

  localparam t_arb_state DFLT   = 2'd0;
  localparam t_arb_state OWN    = 2'd1;
  localparam t_arb_state LOCKED = 2'd2;

  // Beats still to come after the NONSEQ of a burst
  function automatic logic [3:0] burst_beats(t_hburst b);
    case (b)
      HB_WRAP4,  HB_INCR4:  burst_beats = 4'd3;
      HB_WRAP8,  HB_INCR8:  burst_beats = 4'd7;
      HB_WRAP16, HB_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: request/grant and muxed-bus signals seen by the arbiter.
// slave modport is the arbiter side, master the manager/bus side.
interface ahb_arbiter_if #(
  parameter int N_MGR = 4
);
  import ahb_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_MGR);

  logic [N_MGR-1:0] i_hbusreq;
  logic [N_MGR-1:0] i_hlock;
  logic [N_MGR-1:0] o_hgrant;
  logic [IDX_W-1:0] o_hmaster;
  logic [IDX_W-1:0] o_hmaster_d;
  logic             o_hmastlock;
  t_htrans          i_htrans;
  t_hburst          i_hburst;
  logic             i_hready;
  t_hresp           i_hresp;
  logic [N_MGR-1:0] i_hsplit;

  modport slave (
    input  i_hbusreq, i_hlock,
    input  i_htrans, i_hburst,
    input  i_hready, i_hresp,
    input  i_hsplit,
    output o_hgrant, o_hmaster,
    output o_hmaster_d, o_hmastlock
  );

  modport master (
    output i_hbusreq, i_hlock,
    output i_htrans, i_hburst,
    output i_hready, i_hresp,
    output i_hsplit,
    input  o_hgrant, o_hmaster,
    input  o_hmaster_d, o_hmastlock
  );

endinterface

// File: rtl/ahb_arb_rr.sv
// ahb_arb_rr: combinational round-robin picker, search starts after last_i.
// Falls back to dflt_i when nothing requests.
module ahb_arb_rr #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  input  logic [W-1:0] dflt_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  logic         found;
  logic [W-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx_o = dflt_i;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o        = '0;
    gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter with burst/lock protection.
// Define FREEAHB_ARB_SPLIT_EN to mask SPLIT-ed managers until HSPLIT.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int N_MGR       = 4,
  parameter int DEFAULT_MGR = 0
) (
  input logic          i_hclk,
  input logic          i_hreset_n,
  ahb_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_MGR);
  localparam logic [IDX_W-1:0] DIDX = IDX_W'(DEFAULT_MGR);
  localparam logic [N_MGR-1:0] DOH  = N_MGR'(1) << DEFAULT_MGR;

  logic [N_MGR-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] mst_q, mstd_q;
  logic             mlock_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             resp_q;
  t_arb_state       state_q, state_d;
  logic [N_MGR-1:0] split_d;
  logic [N_MGR-1:0] elig;
  logic [N_MGR-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             err_resp, first_resp;
  logic             fixed, last_beat, incr_rel;
  logic             rearb, hold;
  logic             unused_state;

  assign err_resp   = !bus.i_hready && (bus.i_hresp != HR_OKAY);
  assign first_resp = err_resp && !resp_q;
  assign fixed      = bus.i_hburst != HB_INCR;

  assign last_beat = bus.i_hready &&
    ((bus.i_htrans == HT_NONSEQ && bus.i_hburst == HB_SINGLE) ||
     (bus.i_htrans == HT_SEQ && fixed && cnt_q <= 4'd1));

  assign incr_rel = bus.i_hready && !fixed &&
    (bus.i_htrans == HT_NONSEQ || bus.i_htrans == HT_SEQ) &&
    !bus.i_hbusreq[mst_q];

  assign rearb = first_resp || last_beat || incr_rel ||
    (bus.i_hready && bus.i_htrans == HT_IDLE);

`ifdef FREEAHB_ARB_SPLIT_EN
  logic [N_MGR-1:0] split_q;
  logic [N_MGR-1:0] split_set;

  // Set beats clear for the same bit; the default manager is never masked
  always_comb begin
    split_set = '0;
    if (first_resp && bus.i_hresp == HR_SPLIT) split_set[mstd_q] = 1'b1;
    split_d = (split_q & ~bus.i_hsplit) | split_set;
    split_d[DEFAULT_MGR] = 1'b0;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) split_q <= '0;
    else             split_q <= split_d;
  end
`else
  logic unused_hsplit;
  assign unused_hsplit = ^bus.i_hsplit;
  assign split_d       = '0;
`endif

  assign elig = bus.i_hbusreq & ~split_d;
  assign hold = bus.i_hlock[mst_q] && !split_d[mst_q];

  ahb_arb_rr #(
    .N (N_MGR),
    .W (IDX_W)
  ) u_rr (
    .req_i  (elig),
    .last_i (mst_q),
    .dflt_i (DIDX),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    state_d = state_q;
    if (rearb) begin
      if (hold) begin
        gnt_d        = '0;
        gnt_d[mst_q] = 1'b1;
        gidx_d       = mst_q;
        state_d      = LOCKED;
      end else begin
        gnt_d   = pick_gnt;
        gidx_d  = pick_idx;
        state_d = (|elig) ? OWN : DFLT;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      first_resp:
        cnt_d = '0;
      bus.i_hready && bus.i_htrans == HT_NONSEQ:
        cnt_d = burst_beats(bus.i_hburst);
      bus.i_hready && bus.i_htrans == HT_SEQ && fixed && cnt_q != '0:
        cnt_d = cnt_q - 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      gnt_q   <= DOH;
      gidx_q  <= DIDX;
      mst_q   <= DIDX;
      mstd_q  <= DIDX;
      mlock_q <= 1'b0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      state_q <= DFLT;
    end else begin
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      resp_q  <= err_resp;
      state_q <= state_d;
      if (bus.i_hready) begin
        mst_q   <= gidx_q;
        mstd_q  <= mst_q;
        mlock_q <= bus.i_hlock[gidx_q];
      end
    end
  end

  // FSM state is tracked for debug visibility only
  assign unused_state = ^state_q;

  assign bus.o_hgrant    = gnt_q;
  assign bus.o_hmaster   = mst_q;
  assign bus.o_hmaster_d = mstd_q;
  assign bus.o_hmastlock = mlock_q;

endmodule
